// File: rtl/phase_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : phase_accumulator
// Description : NCO phase accumulator producing the 10-bit {cycle, LUT index}
//               word for the downstream 64-point sine generator.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_accumulator #(
    parameter int ACC_W = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] ftw,
    input  logic             ftw_load,
    input  logic [DIV_W-1:0] div,
    input  logic [5:0]       phase_off,
    input  logic             sync,
    output logic [9:0]       t,
    output logic             t_valid,
    output logic             wrap
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_ftw_shadow;
    logic [ACC_W-1:0] r_ftw_act;
    logic             r_pend;
    logic [DIV_W-1:0] r_presc;
    logic [3:0]       r_cyc;
    logic [9:0]       r_t;
    logic             r_t_valid;
    logic             r_wrap;

    logic             w_run;
    logic             w_tick;
    logic             w_xfer;
    logic [ACC_W-1:0] w_ftw_eff;
    logic [ACC_W:0]   w_sum;
    logic [3:0]       w_cyc_next;
    logic [5:0]       w_idx;

    // ">=" rather than "==" so a div shrunk below the running count ticks at once
    assign w_run      = (r_state == c_st_run) && en;
    assign w_tick     = w_run && (r_presc >= div);

    // A pending shadow word is promoted on a real tick, or at any time while idle
    assign w_xfer     = r_pend && ((w_tick && !sync) || (r_state == c_st_idle));
    assign w_ftw_eff  = r_pend ? r_ftw_shadow : r_ftw_act;

    assign w_sum      = {1'b0, r_acc} + {1'b0, w_ftw_eff};
    assign w_cyc_next = r_cyc + {3'b000, w_sum[ACC_W]};
    assign w_idx      = w_sum[ACC_W-1 -: 6] + phase_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_acc        <= '0;
            r_ftw_shadow <= '0;
            r_ftw_act    <= '0;
            r_pend       <= 1'b0;
            r_presc      <= '0;
            r_cyc        <= '0;
            r_t          <= '0;
            r_t_valid    <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_t_valid <= 1'b0;
            r_wrap    <= 1'b0;
            r_state   <= en ? c_st_run : c_st_idle;

            if (ftw_load) begin
                r_ftw_shadow <= ftw;
            end
            if (w_xfer) begin
                r_ftw_act <= r_ftw_shadow;
            end
            if (ftw_load) begin
                r_pend <= 1'b1;
            end else if (w_xfer) begin
                r_pend <= 1'b0;
            end

            if (sync) begin
                r_acc     <= '0;
                r_presc   <= '0;
                r_cyc     <= '0;
                r_t       <= {4'b0000, phase_off};
                r_t_valid <= 1'b1;
            end else if (w_tick) begin
                r_acc     <= w_sum[ACC_W-1:0];
                r_presc   <= '0;
                r_cyc     <= w_cyc_next;
                r_t       <= {w_cyc_next, w_idx};
                r_t_valid <= 1'b1;
                r_wrap    <= w_sum[ACC_W];
            end else if (w_run) begin
                r_presc <= r_presc + DIV_W'(1);
            end else begin
                r_presc <= '0;
            end
        end
    end

    assign t       = r_t;
    assign t_valid = r_t_valid;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire
